// File: rtl/decode_stage_fwd.sv
// decode_stage_fwd: Y86-64 decode stage with F->D register, register file and prioritised forwarding
module decode_stage_fwd #(
    parameter int DATA_W = 64,
    parameter int NREG   = 15,
    parameter int SP_ID  = 4,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_D_stall,
    input  logic              i_D_bubble,
    input  logic [3:0]        i_f_stat,
    input  logic [3:0]        i_f_icode,
    input  logic [3:0]        i_f_ifun,
    input  logic [3:0]        i_f_rA,
    input  logic [3:0]        i_f_rB,
    input  logic [DATA_W-1:0] i_f_valC,
    input  logic [DATA_W-1:0] i_f_valP,
    input  logic [3:0]        i_e_dstE,
    input  logic [3:0]        i_M_dstE,
    input  logic [3:0]        i_M_dstM,
    input  logic [3:0]        i_W_dstE,
    input  logic [3:0]        i_W_dstM,
    input  logic [DATA_W-1:0] i_e_valE,
    input  logic [DATA_W-1:0] i_M_valE,
    input  logic [DATA_W-1:0] i_m_valM,
    input  logic [DATA_W-1:0] i_W_valE,
    input  logic [DATA_W-1:0] i_W_valM,
    input  logic [3:0]        i_E_icode,
    input  logic [3:0]        i_E_dstM,
    output logic [3:0]        o_d_stat,
    output logic [3:0]        o_d_icode,
    output logic [3:0]        o_d_ifun,
    output logic [DATA_W-1:0] o_d_valC,
    output logic [DATA_W-1:0] o_d_valA,
    output logic [DATA_W-1:0] o_d_valB,
    output logic [3:0]        o_d_srcA,
    output logic [3:0]        o_d_srcB,
    output logic [3:0]        o_d_dstE,
    output logic [3:0]        o_d_dstM,
    output logic              o_d_loaduse,
    output logic              o_d_ret
);
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] SP    = 4'(SP_ID);
    localparam logic [3:0] NR    = 4'(NREG);
    localparam int         IW    = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [20+2*DATA_W-1:0] D_NOP = {4'h1, 4'h1, 4'h0, RNONE, RNONE, {(2*DATA_W){1'b0}}};

    logic [3:0]        r_D_stat, r_D_icode, r_D_ifun, r_D_rA, r_D_rB;
    logic [DATA_W-1:0] r_D_valC, r_D_valP;
    logic [DATA_W-1:0] r_rf [NREG];
    logic [DATA_W-1:0] w_rfA, w_rfB;
    logic              w_ins;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            {r_D_stat, r_D_icode, r_D_ifun, r_D_rA, r_D_rB, r_D_valC, r_D_valP} <= D_NOP;
        else if (i_D_bubble)
            {r_D_stat, r_D_icode, r_D_ifun, r_D_rA, r_D_rB, r_D_valC, r_D_valP} <= D_NOP;
        else if (!i_D_stall)
            {r_D_stat, r_D_icode, r_D_ifun, r_D_rA, r_D_rB, r_D_valC, r_D_valP} <=
                {i_f_stat, i_f_icode, i_f_ifun, i_f_rA, i_f_rB, i_f_valC, i_f_valP};
    end

    // RNONE is always >= NR, so the range test also filters "no register"; valM write wins on a tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf <= '{default: '0};
        end else begin
            if (i_W_dstE < NR) r_rf[i_W_dstE[IW-1:0]] <= i_W_valE;
            if (i_W_dstM < NR) r_rf[i_W_dstM[IW-1:0]] <= i_W_valM;
        end
    end

    always_comb begin
        o_d_srcA = (r_D_icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? r_D_rA :
                   (r_D_icode inside {4'h9, 4'hB}) ? SP : RNONE;
        o_d_srcB = (r_D_icode inside {4'h4, 4'h5, 4'h6}) ? r_D_rB :
                   (r_D_icode inside {[4'h8:4'hB]}) ? SP : RNONE;
        o_d_dstE = (r_D_icode inside {4'h2, 4'h3, 4'h6}) ? r_D_rB :
                   (r_D_icode inside {[4'h8:4'hB]}) ? SP : RNONE;
        o_d_dstM = (r_D_icode inside {4'h5, 4'hB}) ? r_D_rA : RNONE;
    end

    assign w_rfA = (o_d_srcA < NR) ? r_rf[o_d_srcA[IW-1:0]] : '0;
    assign w_rfB = (o_d_srcB < NR) ? r_rf[o_d_srcB[IW-1:0]] : '0;

    function automatic logic [DATA_W-1:0] fwd(input logic [3:0] src, input logic [DATA_W-1:0] rf_val);
        return (src == RNONE)           ? '0 :
               !FWD_EN                  ? rf_val :
               (src == i_e_dstE)        ? i_e_valE :
               (src == i_M_dstM)        ? i_m_valM :
               (src == i_M_dstE)        ? i_M_valE :
               (src == i_W_dstM)        ? i_W_valM :
               (src == i_W_dstE)        ? i_W_valE : rf_val;
    endfunction

    function automatic logic bad_id(input logic [3:0] id);
        return (id >= NR) && (id != RNONE);
    endfunction

    always_comb begin
        o_d_valA    = (r_D_icode inside {4'h7, 4'h8}) ? r_D_valP : fwd(o_d_srcA, w_rfA);
        o_d_valB    = fwd(o_d_srcB, w_rfB);
        w_ins       = (r_D_stat == 4'h1) &&
                      (bad_id(o_d_srcA) || bad_id(o_d_srcB) || bad_id(o_d_dstE) || bad_id(o_d_dstM));
        o_d_stat    = w_ins ? 4'h4 : r_D_stat;
        o_d_loaduse = (i_E_icode inside {4'h5, 4'hB}) && (i_E_dstM != RNONE) &&
                      ((i_E_dstM == o_d_srcA) || (i_E_dstM == o_d_srcB));
        o_d_ret     = (r_D_icode == 4'h9);
    end

    assign o_d_icode = r_D_icode;
    assign o_d_ifun  = r_D_ifun;
    assign o_d_valC  = r_D_valC;
endmodule

// File: tb/tb_decode_stage_fwd.sv
// tb_decode_stage_fwd: three builds (default, no forwarding, NREG=8) checked against a spec-level model
module tb_decode_stage_fwd;
    localparam logic [3:0] F = 4'hF;

    logic clk = 1'b0, rst_n = 1'b0;
    logic D_stall, D_bubble;
    logic [3:0] f_stat, f_icode, f_ifun, f_rA, f_rB;
    logic [63:0] f_valC, f_valP;
    logic [3:0] e_dstE, M_dstE, M_dstM, W_dstE, W_dstM, E_icode, E_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;

    logic [3:0] o_stat[3], o_icode[3], o_ifun[3], o_srcA[3], o_srcB[3], o_dstE[3], o_dstM[3];
    logic [63:0] o_valC[3], o_valA[3], o_valB[3];
    logic o_lu[3], o_ret[3];

    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        decode_stage_fwd #(.DATA_W(64), .NREG(g == 2 ? 8 : 15), .SP_ID(4), .FWD_EN(g != 1)) u_dut (
            .clk(clk), .rst_n(rst_n), .i_D_stall(D_stall), .i_D_bubble(D_bubble),
            .i_f_stat(f_stat), .i_f_icode(f_icode), .i_f_ifun(f_ifun), .i_f_rA(f_rA), .i_f_rB(f_rB),
            .i_f_valC(f_valC), .i_f_valP(f_valP),
            .i_e_dstE(e_dstE), .i_M_dstE(M_dstE), .i_M_dstM(M_dstM), .i_W_dstE(W_dstE), .i_W_dstM(W_dstM),
            .i_e_valE(e_valE), .i_M_valE(M_valE), .i_m_valM(m_valM), .i_W_valE(W_valE), .i_W_valM(W_valM),
            .i_E_icode(E_icode), .i_E_dstM(E_dstM),
            .o_d_stat(o_stat[g]), .o_d_icode(o_icode[g]), .o_d_ifun(o_ifun[g]), .o_d_valC(o_valC[g]),
            .o_d_valA(o_valA[g]), .o_d_valB(o_valB[g]), .o_d_srcA(o_srcA[g]), .o_d_srcB(o_srcB[g]),
            .o_d_dstE(o_dstE[g]), .o_d_dstM(o_dstM[g]), .o_d_loaduse(o_lu[g]), .o_d_ret(o_ret[g]));
    end

    // reference state: the D register contents and one register array per build
    logic [3:0] md_stat, md_icode, md_ifun, md_rA, md_rB;
    logic [63:0] md_valC, md_valP;
    logic [63:0] mrf[3][16];

    function automatic int nreg(int k);
        return (k == 2) ? 8 : 15;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || D_bubble) begin
            md_stat <= 1; md_icode <= 1; md_ifun <= 0; md_rA <= F; md_rB <= F; md_valC <= 0; md_valP <= 0;
        end else if (!D_stall) begin
            md_stat <= f_stat; md_icode <= f_icode; md_ifun <= f_ifun; md_rA <= f_rA; md_rB <= f_rB;
            md_valC <= f_valC; md_valP <= f_valP;
        end
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                for (int r = 0; r < 16; r++) mrf[k][r] <= 0;
            end else begin
                if (W_dstE != F && int'(W_dstE) < nreg(k)) mrf[k][W_dstE] <= W_valE;
                if (W_dstM != F && int'(W_dstM) < nreg(k)) mrf[k][W_dstM] <= W_valM;
            end
        end
    end

    typedef struct packed {
        logic [3:0] stat, icode, ifun, srcA, srcB, dstE, dstM;
        logic [63:0] valC, valA, valB;
        logic lu, ret;
    } out_t;

    function automatic logic [63:0] pick(int k, logic [3:0] src);
        if (src == F) return 0;
        if (k != 1) begin
            if (src == e_dstE) return e_valE;
            if (src == M_dstM) return m_valM;
            if (src == M_dstE) return M_valE;
            if (src == W_dstM) return W_valM;
            if (src == W_dstE) return W_valE;
        end
        return (int'(src) < nreg(k)) ? mrf[k][src] : 64'h0;
    endfunction

    function automatic bit badr(int k, logic [3:0] id);
        return id != F && int'(id) >= nreg(k);
    endfunction

    function automatic out_t model(int k);
        out_t o;
        o.icode = md_icode; o.ifun = md_ifun; o.valC = md_valC;
        case (md_icode)
            4'h2, 4'h4, 4'h6, 4'hA: o.srcA = md_rA;
            4'h9, 4'hB:             o.srcA = 4;
            default:                o.srcA = F;
        endcase
        case (md_icode)
            4'h4, 4'h5, 4'h6:       o.srcB = md_rB;
            4'h8, 4'h9, 4'hA, 4'hB: o.srcB = 4;
            default:                o.srcB = F;
        endcase
        case (md_icode)
            4'h2, 4'h3, 4'h6:       o.dstE = md_rB;
            4'h8, 4'h9, 4'hA, 4'hB: o.dstE = 4;
            default:                o.dstE = F;
        endcase
        o.dstM = (md_icode == 5 || md_icode == 11) ? md_rA : F;
        o.valA = (md_icode == 7 || md_icode == 8) ? md_valP : pick(k, o.srcA);
        o.valB = pick(k, o.srcB);
        o.stat = (md_stat == 1 && (badr(k, o.srcA) || badr(k, o.srcB) || badr(k, o.dstE) || badr(k, o.dstM)))
                 ? 4'h4 : md_stat;
        o.lu = (E_icode == 5 || E_icode == 11) && E_dstM != F && (E_dstM == o.srcA || E_dstM == o.srcB);
        o.ret = md_icode == 9;
        return o;
    endfunction

    task automatic cmp(string nm, int k, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[inst%0d] @%0t: got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 3; k++) begin
            out_t e = model(k);
            cmp("stat", k, o_stat[k], e.stat);   cmp("icode", k, o_icode[k], e.icode);
            cmp("ifun", k, o_ifun[k], e.ifun);   cmp("valC", k, o_valC[k], e.valC);
            cmp("valA", k, o_valA[k], e.valA);   cmp("valB", k, o_valB[k], e.valB);
            cmp("srcA", k, o_srcA[k], e.srcA);   cmp("srcB", k, o_srcB[k], e.srcB);
            cmp("dstE", k, o_dstE[k], e.dstE);   cmp("dstM", k, o_dstM[k], e.dstM);
            cmp("loaduse", k, o_lu[k], e.lu);    cmp("ret", k, o_ret[k], e.ret);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_model();
    endtask

    task automatic clr();
        e_dstE = F; M_dstE = F; M_dstM = F; W_dstE = F; W_dstM = F; E_icode = 1; E_dstM = F;
        e_valE = 0; M_valE = 0; m_valM = 0; W_valE = 0; W_valM = 0;
    endtask

    task automatic set_f(logic [3:0] ic, logic [3:0] fn, logic [3:0] ra, logic [3:0] rb,
                         logic [63:0] vc, logic [63:0] vp);
        f_icode = ic; f_ifun = fn; f_rA = ra; f_rB = rb; f_valC = vc; f_valP = vp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr(); D_stall = 0; D_bubble = 0; f_stat = 1; set_f(1, 0, F, F, 0, 0);
        tick(); tick();
        cmp("rst_icode", 0, o_icode[0], 1);  cmp("rst_stat", 0, o_stat[0], 1);
        cmp("rst_srcA", 0, o_srcA[0], F);    cmp("rst_dstM", 0, o_dstM[0], F);
        cmp("rst_valA", 0, o_valA[0], 0);    cmp("rst_valB", 0, o_valB[0], 0);
        rst_n = 1;
        // register file write then read back once W has moved on
        W_dstE = 5; W_valE = 'h55; set_f(2, 0, 5, 6, 0, 'h2); tick();
        clr(); #1;
        cmp("rf_valA", 0, o_valA[0], 'h55); cmp("rf_valA_nofwd", 1, o_valA[1], 'h55);
        cmp("rr_dstE", 0, o_dstE[0], 6);
        W_dstE = 4; W_valE = 'h10; W_dstM = 4; W_valM = 'h20; set_f(11, 0, 4, F, 0, 'h4); tick();
        cmp("pop_valA", 0, o_valA[0], 'h20); cmp("pop_dstM", 0, o_dstM[0], 4);
        cmp("pop_srcB", 0, o_srcB[0], 4);
        clr(); set_f(2, 0, 4, 1, 0, 'h6); tick();
        cmp("rsp_rf", 0, o_valA[0], 'h20);   cmp("rsp_rf_nofwd", 1, o_valA[1], 'h20);
        // forwarding priority
        W_dstE = 2; W_valE = 'h22; W_dstM = 3; W_valM = 'h33; set_f(6, 0, 2, 3, 0, 'h8); tick();
        clr();
        e_dstE = 2; e_valE = 'hA; W_dstE = 2; W_valE = 'hB; M_dstE = 3; M_valE = 'hC; #1;
        cmp("pri_valA", 0, o_valA[0], 'hA);  cmp("pri_valB", 0, o_valB[0], 'hC);
        cmp("nofwd_valA", 1, o_valA[1], 'h22); cmp("nofwd_valB", 1, o_valB[1], 'h33);
        tick();
        e_dstE = F; M_dstM = 2; m_valM = 'h77; M_dstE = 2; M_valE = 'h88;
        W_dstM = 3; W_valM = 'h99; W_dstE = 3; W_valE = 'hAA; #1;
        cmp("pri2_valA", 0, o_valA[0], 'h77); cmp("pri2_valB", 0, o_valB[0], 'h99);
        cmp("nofwd2_valA", 1, o_valA[1], 'hB);
        tick(); clr();
        // stall and bubble
        set_f(3, 0, F, 7, 'h1234, 'h10A); tick();
        cmp("irm_icode", 0, o_icode[0], 3);  cmp("irm_valC", 0, o_valC[0], 'h1234);
        cmp("irm_dstE", 0, o_dstE[0], 7);
        D_stall = 1; set_f(6, 1, 1, 2, 'h9, 'h10C); tick(); tick();
        cmp("stall_icode", 0, o_icode[0], 3); cmp("stall_valC", 0, o_valC[0], 'h1234);
        D_bubble = 1; tick();
        cmp("bub_icode", 0, o_icode[0], 1);  cmp("bub_valC", 0, o_valC[0], 0);
        cmp("bub_dstE", 0, o_dstE[0], F);
        D_stall = 0; D_bubble = 0;
        // load-use and ret
        set_f(6, 0, 3, 1, 0, 'h20); tick();
        E_icode = 5; E_dstM = 3; #1; cmp("lu_on", 0, o_lu[0], 1);
        E_dstM = F; #1; cmp("lu_none", 0, o_lu[0], 0);
        E_icode = 11; E_dstM = 1; tick(); cmp("lu_pop_srcB", 0, o_lu[0], 1);
        clr(); set_f(9, 0, F, F, 0, 'h22); tick();
        cmp("ret", 0, o_ret[0], 1); cmp("ret_srcA", 0, o_srcA[0], 4); cmp("ret_valA", 0, o_valA[0], 'h20);
        // call, then out-of-range register IDs
        set_f(8, 0, F, F, 'h200, 'h100); tick();
        cmp("call_valA", 0, o_valA[0], 'h100); cmp("call_srcB", 0, o_srcB[0], 4);
        cmp("call_dstE", 0, o_dstE[0], 4);     cmp("call_valB", 0, o_valB[0], 'h20);
        cmp("call_ret", 0, o_ret[0], 0);
        set_f(6, 0, 9, 1, 0, 'h10); tick();
        cmp("ins_n8", 2, o_stat[2], 4); cmp("ins_n15", 0, o_stat[0], 1);
        f_stat = 2; tick(); cmp("hlt_n8", 2, o_stat[2], 2); f_stat = 1;
        // asynchronous reset mid-cycle clears D and the register file
        set_f(6, 0, 2, 3, 0, 'h30); tick();
        @(posedge clk); #2; rst_n = 0; #1;
        cmp("mid_icode", 0, o_icode[0], 1); cmp("mid_srcA", 0, o_srcA[0], F); cmp("mid_valA", 0, o_valA[0], 0);
        tick(); rst_n = 1;
        set_f(2, 0, 2, 6, 0, 0); tick();
        cmp("rf_clr", 0, o_valA[0], 0); cmp("rf_clr_nofwd", 1, o_valA[1], 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
